// File: rtl/au_dispatch_ctrl.sv
// au_dispatch_ctrl: issues opcode/operand requests to the AU and returns its captured result
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 3
`endif
`ifndef NOP
`define NOP 3'd0
`endif
`ifndef ADD
`define ADD 3'd1
`endif
`ifndef SUB
`define SUB 3'd2
`endif
`ifndef MULT
`define MULT 3'd3
`endif
`ifndef DIV
`define DIV 3'd4
`endif
module au_dispatch_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int OPCODE_WIDTH = `OPCODE_WIDTH,
  parameter int EN_HIGH_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    Global_clk,
  input  logic                    Global_reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_opcode,
  input  logic [DATA_WIDTH-1:0]   req_op_a,
  input  logic [DATA_WIDTH-1:0]   req_op_b,
  output logic [OPCODE_WIDTH-1:0] Mode,
  output logic [DATA_WIDTH-1:0]   AU_in_1,
  output logic [DATA_WIDTH-1:0]   AU_in_2,
  output logic                    AU_op_enable,
  input  logic [DATA_WIDTH-1:0]   AU_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic [15:0]             stall_count
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, FIRE = 3'd2, SETTLE = 3'd3, RESP = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(`NOP), OP_ADD = OPCODE_WIDTH'(`ADD),
    OP_SUB = OPCODE_WIDTH'(`SUB), OP_MULT = OPCODE_WIDTH'(`MULT), OP_DIV = OPCODE_WIDTH'(`DIV);
  localparam int CMAX = EN_HIGH_CYCLES > SETTLE_CYCLES ? EN_HIGH_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] EN_LAST = CW'(EN_HIGH_CYCLES - 1), SET_LAST = CW'(SETTLE_CYCLES - 1);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic live_q, en_q, en_d, rerr_q, rerr_d;
  logic [OPCODE_WIDTH-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, rdata_q, rdata_d;
  logic [15:0] stall_q, stall_d;
  logic accept, is_nop, is_bad, load, err_acc, last, capture;
  // ready only once a clock has been seen after reset release, and only while idle
  assign req_ready = live_q && state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign is_nop = req_opcode == OP_NOP;
  assign is_bad = (req_opcode == OP_DIV && req_op_b == '0) ||
                  !(req_opcode inside {OP_ADD, OP_SUB, OP_MULT, OP_DIV});
  assign load = accept && !is_nop && !is_bad;
  assign err_acc = accept && !is_nop && is_bad;
  assign last = cnt_q == (state_q == FIRE ? EN_LAST : SET_LAST);
  assign capture = state_q == SETTLE && last;
  assign Mode = mode_q;
  assign AU_in_1 = in1_q;
  assign AU_in_2 = in2_q;
  assign AU_op_enable = en_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rdata_q;
  assign rsp_err = rerr_q;
  assign stall_count = stall_q;
  // sequencing: operands settle a full cycle, enable held, result sampled after settle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept || is_nop ? IDLE : is_bad ? RESP : SETUP;
      SETUP:   state_d = FIRE;
      FIRE:    state_d = last ? SETTLE : FIRE;
      SETTLE:  state_d = last ? RESP : SETTLE;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // datapath next-state: enable is registered so the strobe never glitches
  always_comb begin
    cnt_d = (state_q == FIRE || state_q == SETTLE) && !last ? cnt_q + CW'(1) : '0;
    en_d = state_d == FIRE;
    mode_d = load ? req_opcode : mode_q;
    in1_d = load ? req_op_a : in1_q;
    in2_d = load ? req_op_b : in2_q;
    rdata_d = err_acc ? '0 : capture ? AU_out : rdata_q;
    rerr_d = err_acc ? 1'b1 : capture ? 1'b0 : rerr_q;
    stall_d = accept && is_nop && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
  end
  // state registers; reset abandons any in-flight operation
  always_ff @(posedge Global_clk or posedge Global_reset)
    if (Global_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      live_q <= 1'b0;
      en_q <= 1'b0;
      mode_q <= OP_NOP;
      in1_q <= '0;
      in2_q <= '0;
      rdata_q <= '0;
      rerr_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      live_q <= 1'b1;
      en_q <= en_d;
      mode_q <= mode_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      rdata_q <= rdata_d;
      rerr_q <= rerr_d;
      stall_q <= stall_d;
    end
endmodule
